// File: rtl/musicbox_pkg.sv
// Shared definitions for the music box mode controller: mode indices,
// sequencer state encoding and seven-segment field positions.
package musicbox_pkg;

  localparam int MODE_MUSIC_BOX = 0;
  localparam int MODE_ELECTONE  = 1;
  localparam int MODE_WRITING   = 2;
  localparam int MODE_REPLAY    = 3;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2
  } seq_state_t;

  localparam int SEG_DIGIT_LSB = 0;
  localparam int SEG_LEN_LSB   = 16;
  localparam int SEG_MODE_LSB  = 28;
  localparam int SEG_FIELD_W   = 3;

endpackage

// File: rtl/mode_next_finder.sv
// Combinational search for the next enabled mode above cur, wrapping to 0.
// found is low when no mode other than cur is enabled.
module mode_next_finder
  import musicbox_pkg::*;
#(
  parameter int NUM_MODES = 4,
  localparam int MW = $clog2(NUM_MODES)
) (
  input  logic [MW-1:0]        cur,
  input  logic [NUM_MODES-1:0] mask,
  output logic [MW-1:0]        nxt,
  output logic                 found
);

  logic [MW-1:0] cand;

  // Walk distances from farthest to nearest so the nearest enabled mode wins.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    cand  = '0;
    for (int k = NUM_MODES - 1; k >= 1; k--) begin
      cand = MW'((int'(cur) + k) % NUM_MODES);
      if (mask[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Mode controller for the music box: steps through enabled modes, draining the
// player before each commit. Defining MODE_SEQ_DIRECT_EN adds a direct mode load.
//
// state     | meaning
// ST_ACTIVE | mode committed, routing live, watching step / load / mask loss
// ST_DRAIN  | quiesce high, waiting for busy low or the drain timeout
// ST_COMMIT | single cycle: mode takes target, routing forced to 0
module mode_sequencer
  import musicbox_pkg::*;
#(
  parameter int NUM_MODES = 4,
  parameter int SW_W      = 16,
  parameter int DRAIN_MAX = 255,
  localparam int MW = $clog2(NUM_MODES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode_step,
  input  logic [NUM_MODES-1:0] mode_en_mask,
  input  logic                 busy,
  input  logic [SW_W-1:0]      sw,
  input  logic [SW_W-1:0]      player_note,
  input  logic                 btn_inc,
  input  logic                 btn_dec,
  input  logic [2:0]           sel_digit,
  input  logic [2:0]           band,
  input  logic [2:0]           len,
  output logic [MW-1:0]        mode,
  output logic [NUM_MODES-1:0] mode_onehot,
  output logic                 quiesce,
  output logic                 switching,
  output logic                 drain_timeout,
  output logic [SW_W-1:0]      note_out,
  output logic                 next_pulse,
  output logic                 prev_pulse,
  output logic                 add_pulse,
  output logic                 redu_pulse,
  output logic                 adj,
  output logic [31:0]          seg_data
`ifdef MODE_SEQ_DIRECT_EN
  ,
  input  logic                 mode_load,
  input  logic [MW-1:0]        mode_load_idx
`endif
);

  localparam int CW = $clog2(DRAIN_MAX + 1);

  seq_state_t      state;
  logic [MW-1:0]   target;
  logic [CW-1:0]   drain_cnt;

  logic [MW-1:0]   step_idx;
  logic            step_found;
  logic            go;
  logic [MW-1:0]   go_idx;

  logic [SW_W-1:0] note_d;
  logic            next_d, prev_d, add_d, redu_d, adj_d;
  logic [31:0]     seg_d;

  mode_next_finder #(
    .NUM_MODES (NUM_MODES)
  ) u_next_finder (
    .cur   (mode),
    .mask  (mode_en_mask),
    .nxt   (step_idx),
    .found (step_found)
  );

`ifdef MODE_SEQ_DIRECT_EN
  logic load_ok;
  assign load_ok = (int'(mode_load_idx) < NUM_MODES) &&
                   mode_en_mask[mode_load_idx] && (mode_load_idx != mode);
`endif

  // Losing the enable bit of the current mode acts like a step request.
  always_comb begin
    go     = 1'b0;
    go_idx = step_idx;
    if (step_found && (mode_step || !mode_en_mask[mode])) begin
      go = 1'b1;
    end
`ifdef MODE_SEQ_DIRECT_EN
    if (mode_load && load_ok) begin
      go     = 1'b1;
      go_idx = mode_load_idx;
    end
`endif
  end

  // Routing is only live in ACTIVE; modes without a case entry are idle.
  always_comb begin
    note_d = '0;
    next_d = 1'b0;
    prev_d = 1'b0;
    add_d  = 1'b0;
    redu_d = 1'b0;
    adj_d  = 1'b0;
    if (state == ST_ACTIVE) begin
      case (int'(mode))
        MODE_MUSIC_BOX: begin
          note_d = player_note;
          next_d = btn_inc;
          prev_d = btn_dec;
          adj_d  = 1'b1;
        end
        MODE_ELECTONE: begin
          note_d = sw;
          add_d  = btn_inc;
          redu_d = btn_dec;
        end
        MODE_WRITING, MODE_REPLAY: note_d = sw;
        default: ;
      endcase
    end
  end

  always_comb begin
    seg_d = '0;
    seg_d[SEG_MODE_LSB +: SEG_FIELD_W] = SEG_FIELD_W'(mode);
    if (int'(mode) == MODE_MUSIC_BOX) begin
      seg_d[SEG_DIGIT_LSB +: SEG_FIELD_W] = sel_digit;
      seg_d[SEG_LEN_LSB   +: SEG_FIELD_W] = len;
    end else begin
      seg_d[SEG_DIGIT_LSB +: SEG_FIELD_W] = band;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_ACTIVE;
      mode          <= '0;
      mode_onehot   <= NUM_MODES'(1);
      target        <= '0;
      drain_cnt     <= '0;
      quiesce       <= 1'b0;
      switching     <= 1'b0;
      drain_timeout <= 1'b0;
      note_out      <= '0;
      next_pulse    <= 1'b0;
      prev_pulse    <= 1'b0;
      add_pulse     <= 1'b0;
      redu_pulse    <= 1'b0;
      adj           <= 1'b0;
      seg_data      <= '0;
    end else begin
      note_out      <= note_d;
      next_pulse    <= next_d;
      prev_pulse    <= prev_d;
      add_pulse     <= add_d;
      redu_pulse    <= redu_d;
      adj           <= adj_d;
      seg_data      <= seg_d;
      drain_timeout <= 1'b0;
      unique case (state)
        ST_ACTIVE: begin
          if (go) begin
            target    <= go_idx;
            drain_cnt <= CW'(DRAIN_MAX - 1);
            quiesce   <= 1'b1;
            switching <= 1'b1;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!busy) begin
            quiesce <= 1'b0;
            state   <= ST_COMMIT;
          end else if (drain_cnt == '0) begin
            quiesce       <= 1'b0;
            drain_timeout <= 1'b1;
            state         <= ST_COMMIT;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        ST_COMMIT: begin
          mode        <= target;
          mode_onehot <= NUM_MODES'(1) << target;
          switching   <= 1'b0;
          state       <= ST_ACTIVE;
        end
        default: begin
          quiesce   <= 1'b0;
          switching <= 1'b0;
          state     <= ST_ACTIVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed plus randomized bench for mode_sequencer (default build), checked
// every cycle against a behavioural model of the mode/drain rules.
`timescale 1ns/1ps
module tb_mode_sequencer;

  localparam int N    = 4;
  localparam int SW_W = 16;
  localparam int DMAX = 8;

  logic            clk = 1'b0;
  logic            rst, mode_step, busy, btn_inc, btn_dec;
  logic [N-1:0]    mask;
  logic [SW_W-1:0] sw, player_note;
  logic [2:0]      sel_digit, band, len;

  logic [1:0]      mode;
  logic [N-1:0]    mode_onehot;
  logic            quiesce, switching, drain_timeout;
  logic [SW_W-1:0] note_out;
  logic            next_pulse, prev_pulse, add_pulse, redu_pulse, adj;
  logic [31:0]     seg_data;

  always #5 clk = ~clk;

  mode_sequencer #(
    .NUM_MODES (N),
    .SW_W      (SW_W),
    .DRAIN_MAX (DMAX)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mode_step     (mode_step),
    .mode_en_mask  (mask),
    .busy          (busy),
    .sw            (sw),
    .player_note   (player_note),
    .btn_inc       (btn_inc),
    .btn_dec       (btn_dec),
    .sel_digit     (sel_digit),
    .band          (band),
    .len           (len),
    .mode          (mode),
    .mode_onehot   (mode_onehot),
    .quiesce       (quiesce),
    .switching     (switching),
    .drain_timeout (drain_timeout),
    .note_out      (note_out),
    .next_pulse    (next_pulse),
    .prev_pulse    (prev_pulse),
    .add_pulse     (add_pulse),
    .redu_pulse    (redu_pulse),
    .adj           (adj),
    .seg_data      (seg_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: committed mode, pending target and where the switch is.
  int m_mode = 0, m_target = 0, m_drain_cycles = 0;
  bit m_in_drain = 0, m_in_commit = 0;

  int              e_mode = 0;
  logic [N-1:0]    e_onehot = 1;
  bit              e_quiesce, e_switching, e_timeout;
  logic [SW_W-1:0] e_note;
  bit              e_next, e_prev, e_add, e_redu, e_adj;
  logic [31:0]     e_seg;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit enabled(input logic [N-1:0] m, input int idx);
    return ((m >> idx) & 1) != 0;
  endfunction

  function automatic int find_next(input int cur, input logic [N-1:0] m);
    for (int k = 1; k < N; k++)
      if (enabled(m, (cur + k) % N)) return (cur + k) % N;
    return -1;
  endfunction

  task automatic model_step();
    int f;
    e_timeout = 0;
    if (rst) begin
      m_mode = 0; m_target = 0; m_drain_cycles = 0;
      m_in_drain = 0; m_in_commit = 0;
      e_quiesce = 0; e_switching = 0;
      e_note = '0; e_next = 0; e_prev = 0; e_add = 0; e_redu = 0; e_adj = 0;
      e_seg = '0;
    end else begin
      e_note = '0; e_next = 0; e_prev = 0; e_add = 0; e_redu = 0; e_adj = 0;
      if (!m_in_drain && !m_in_commit) begin
        if (m_mode == 0) begin
          e_note = player_note; e_next = btn_inc; e_prev = btn_dec; e_adj = 1;
        end else if (m_mode == 1) begin
          e_note = sw; e_add = btn_inc; e_redu = btn_dec;
        end else begin
          e_note = sw;
        end
      end
      e_seg = {1'b0, 3'(m_mode), 9'b0, (m_mode == 0) ? len : 3'b0, 13'b0,
               (m_mode == 0) ? sel_digit : band};
      if (m_in_commit) begin
        m_mode = m_target; m_in_commit = 0; e_switching = 0;
      end else if (m_in_drain) begin
        m_drain_cycles++;
        if (!busy || m_drain_cycles == DMAX) begin
          e_timeout = busy;
          m_in_drain = 0; m_in_commit = 1; e_quiesce = 0;
        end
      end else begin
        f = find_next(m_mode, mask);
        if (f >= 0 && (mode_step || !enabled(mask, m_mode))) begin
          m_target = f; m_in_drain = 1; m_drain_cycles = 0;
          e_quiesce = 1; e_switching = 1;
        end
      end
    end
    e_mode = m_mode;
    e_onehot = N'(1 << m_mode);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("mode",          64'(mode),          64'(e_mode));
    chk("mode_onehot",   64'(mode_onehot),   64'(e_onehot));
    chk("quiesce",       64'(quiesce),       64'(e_quiesce));
    chk("switching",     64'(switching),     64'(e_switching));
    chk("drain_timeout", 64'(drain_timeout), 64'(e_timeout));
    chk("note_out",      64'(note_out),      64'(e_note));
    chk("next_pulse",    64'(next_pulse),    64'(e_next));
    chk("prev_pulse",    64'(prev_pulse),    64'(e_prev));
    chk("add_pulse",     64'(add_pulse),     64'(e_add));
    chk("redu_pulse",    64'(redu_pulse),    64'(e_redu));
    chk("adj",           64'(adj),           64'(e_adj));
    chk("seg_data",      64'(seg_data),      64'(e_seg));
  endtask

  initial begin
    int q_cnt, t_cnt;
    rst = 1; mode_step = 0; busy = 0; btn_inc = 0; btn_dec = 0; mask = 4'b1111;
    sw = '0; player_note = '0; sel_digit = '0; band = '0; len = '0;

    cycle();
    chk("rst_mode", 64'(mode), 64'd0);
    chk("rst_onehot", 64'(mode_onehot), 64'd1);
    chk("rst_seg", 64'(seg_data), 64'd0);
    cycle();
    rst = 0;

    // first step, busy low: two switching cycles then mode 1
    mode_step = 1; cycle(); mode_step = 0;
    chk("switch_c1", 64'(switching), 64'd1);
    cycle();
    chk("switch_c2", 64'(switching), 64'd1);
    chk("mode_c2", 64'(mode), 64'd0);
    cycle();
    chk("mode_c3", 64'(mode), 64'd1);
    chk("switch_c3", 64'(switching), 64'd0);

    // skip the masked mode, then wrap
    mask = 4'b1011;
    mode_step = 1; cycle(); mode_step = 0; cycle(); cycle();
    chk("skip_to_3", 64'(mode), 64'd3);
    chk("onehot_3", 64'(mode_onehot), 64'h8);
    mode_step = 1; cycle(); mode_step = 0; cycle(); cycle();
    chk("wrap_to_0", 64'(mode), 64'd0);

    // music box routing
    player_note = 16'h1234; sel_digit = 3'd5; len = 3'd6; band = 3'd2;
    btn_inc = 1; cycle(); btn_inc = 0;
    chk("mb_next", 64'(next_pulse), 64'd1);
    chk("mb_add", 64'(add_pulse), 64'd0);
    chk("mb_note", 64'(note_out), 64'h1234);
    chk("mb_adj", 64'(adj), 64'd1);
    cycle();
    chk("mb_next_off", 64'(next_pulse), 64'd0);
    chk("mb_seg", 64'(seg_data), 64'h0006_0005);
    btn_dec = 1; cycle(); btn_dec = 0;
    chk("mb_prev", 64'(prev_pulse), 64'd1);

    // electone routing
    mode_step = 1; cycle(); mode_step = 0; cycle(); cycle();
    chk("to_electone", 64'(mode), 64'd1);
    sw = 16'hA5A5;
    btn_dec = 1; cycle(); btn_dec = 0;
    chk("el_redu", 64'(redu_pulse), 64'd1);
    chk("el_prev", 64'(prev_pulse), 64'd0);
    chk("el_note", 64'(note_out), 64'hA5A5);
    chk("el_adj", 64'(adj), 64'd0);
    cycle();
    chk("el_seg", 64'(seg_data), 64'h1000_0002);

    // busy stuck high: forced commit after DMAX drain cycles
    busy = 1; btn_inc = 1; mode_step = 1; cycle(); mode_step = 0;
    chk("add_old_mode", 64'(add_pulse), 64'd1);
    chk("drain_quiesce", 64'(quiesce), 64'd1);
    q_cnt = 1; t_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (i == 2) chk("add_in_drain", 64'(add_pulse), 64'd0);
      q_cnt += int'(quiesce);
      t_cnt += int'(drain_timeout);
    end
    btn_inc = 0; busy = 0;
    chk("drain_len", 64'(q_cnt), 64'(DMAX));
    chk("timeout_pulses", 64'(t_cnt), 64'd1);
    chk("timeout_mode", 64'(mode), 64'd3);

    mode_step = 1; cycle(); mode_step = 0; cycle(); cycle();
    chk("back_to_0", 64'(mode), 64'd0);

    // only the current mode enabled: step ignored
    mask = 4'b0001;
    mode_step = 1; cycle(); mode_step = 0;
    chk("no_drain", 64'(switching), 64'd0);
    cycle();
    chk("no_drain_mode", 64'(mode), 64'd0);

    // current mode loses its enable
    mask = 4'b0100;
    cycle();
    chk("implicit_drain", 64'(switching), 64'd1);
    cycle(); cycle();
    chk("implicit_mode", 64'(mode), 64'd2);

    // reset in the middle of a drain
    mask = 4'b1111; busy = 1;
    mode_step = 1; cycle(); mode_step = 0;
    cycle();
    chk("pre_rst_quiesce", 64'(quiesce), 64'd1);
    rst = 1; cycle(); rst = 0; busy = 0;
    chk("rst_drain_mode", 64'(mode), 64'd0);
    chk("rst_drain_quiesce", 64'(quiesce), 64'd0);
    chk("rst_drain_seg_mode", 64'(seg_data[30:28]), 64'd0);
    for (int i = 0; i < 4; i++) cycle();
    chk("target_abandoned", 64'(mode), 64'd0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      mode_step   = ($urandom_range(0, 5) == 0);
      busy        = ($urandom_range(0, 2) != 0);
      btn_inc     = 1'($urandom_range(0, 1));
      btn_dec     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 30) == 0) mask = 4'($urandom);
      sw          = 16'($urandom);
      player_note = 16'($urandom);
      sel_digit   = 3'($urandom);
      band        = 3'($urandom);
      len         = 3'($urandom);
      rst         = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 0; mode_step = 0; busy = 0; btn_inc = 0; btn_dec = 0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
